// File: rtl/button_event_gen_pkg.sv
// rtl/button_event_gen_pkg.sv - shared state encoding and event bundle for button consumers
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  // One bit per one-cycle event; held is a level and lives outside the bundle.
  typedef struct packed {
    logic press_ev;
    logic release_ev;
    logic short_ev;
    logic long_ev;
    logic repeat_ev;
  } btn_events_t;

  localparam int EVENT_W = $bits(btn_events_t);

endpackage

// File: rtl/button_event_gen_if.sv
// rtl/button_event_gen_if.sv - debounced level in, event pulses and held level out
interface button_event_gen_if;

  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    input  btn_level,
    output press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    output btn_level,
    input  press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - press/release/short/long/repeat event generator
// Edge detect, hold counter and FSM in one flat block; all outputs registered.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000,
  parameter int CNT_W             = 26
) (
  input  logic                clk,
  input  logic                rst,
  button_event_gen_if.master  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_q;
  logic             press;
  btn_events_t      ev, ev_nxt;
  logic             held_q;

  // btn_q resets high so a button held through reset must be seen low first.
  assign press = bus.btn_level & ~btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      btn_q  <= 1'b1;
      ev     <= '0;
      held_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      btn_q  <= bus.btn_level;
      ev     <= ev_nxt;
      held_q <= (state_nxt != IDLE);
    end
  end

  // Release is tested before any threshold so a low level always wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ev_nxt    = '0;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt       = PRESSED;
          cnt_nxt         = CNT_ONE;
          ev_nxt.press_ev = 1'b1;
        end
      end
      PRESSED: begin
        if (!bus.btn_level) begin
          state_nxt         = IDLE;
          cnt_nxt           = '0;
          ev_nxt.release_ev = 1'b1;
          ev_nxt.short_ev   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt      = LONG;
          cnt_nxt        = CNT_ONE;
          ev_nxt.long_ev = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG: begin
        if (!bus.btn_level) begin
          state_nxt         = IDLE;
          cnt_nxt           = '0;
          ev_nxt.release_ev = 1'b1;
        end else if (cnt == REP_LAST) begin
          cnt_nxt          = CNT_ONE;
          ev_nxt.repeat_ev = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.press_pulse   = ev.press_ev;
  assign bus.release_pulse = ev.release_ev;
  assign bus.short_pulse   = ev.short_ev;
  assign bus.long_pulse    = ev.long_ev;
  assign bus.repeat_pulse  = ev.repeat_ev;
  assign bus.held          = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - directed self-checking bench for button_event_gen
module tb_button_event_gen;

  // Expected output vector bits: {press, release, short, long, repeat, held}
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] S  = 6'b001000;
  localparam logic [5:0] L  = 6'b000100;
  localparam logic [5:0] RP = 6'b000010;
  localparam logic [5:0] H  = 6'b000001;
  localparam logic [5:0] Z  = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  button_event_gen_if bus ();

  button_event_gen #(
    .LONG_PRESS_CYCLES(8),
    .REPEAT_CYCLES    (4),
    .CNT_W            (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs for one edge, then sample the registered outputs 1ns after it.
  task automatic step(input string tag, input logic b, input logic r, input logic [5:0] exp);
    bus.btn_level = b;
    rst = r;
    @(posedge clk);
    #1;
    check_eq(tag, {bus.press_pulse, bus.release_pulse, bus.short_pulse,
                   bus.long_pulse, bus.repeat_pulse, bus.held}, exp);
  endtask

  initial begin
    bus.btn_level = 1'b1;
    rst = 1'b1;

    // Held through reset from power-up: no events until a low-to-high transition.
    for (int i = 0; i < 3; i++) step("reset_state", 1'b1, 1'b1, Z);
    for (int i = 0; i < 12; i++) step("held_thru_reset", 1'b1, 1'b0, Z);
    step("held_thru_reset_low", 1'b0, 1'b0, Z);
    step("idle_low", 1'b0, 1'b0, Z);

    // Tap: high 0-2, low at 3.
    step("tap_e0", 1'b1, 1'b0, P | H);
    step("tap_e1", 1'b1, 1'b0, H);
    step("tap_e2", 1'b1, 1'b0, H);
    step("tap_e3", 1'b0, 1'b0, R | S);
    step("tap_e4", 1'b0, 1'b0, Z);

    // Hold: high 0-19, low at 20.
    for (int e = 0; e < 20; e++) begin
      if (e == 0)                          step("hold_press", 1'b1, 1'b0, P | H);
      else if (e == 7)                     step("hold_long", 1'b1, 1'b0, L | H);
      else if (e == 11 || e == 15 || e == 19) step("hold_repeat", 1'b1, 1'b0, RP | H);
      else                                 step("hold_held", 1'b1, 1'b0, H);
    end
    step("hold_release", 1'b0, 1'b0, R);
    step("hold_idle", 1'b0, 1'b0, Z);

    // Boundary: high 0-6, low at 7 -> short, no long.
    step("bnd_a_e0", 1'b1, 1'b0, P | H);
    for (int e = 1; e < 7; e++) step("bnd_a_held", 1'b1, 1'b0, H);
    step("bnd_a_e7", 1'b0, 1'b0, R | S);
    step("bnd_a_idle", 1'b0, 1'b0, Z);

    // Boundary: high 0-7, low at 8 -> long at 7, release only.
    step("bnd_b_e0", 1'b1, 1'b0, P | H);
    for (int e = 1; e < 7; e++) step("bnd_b_held", 1'b1, 1'b0, H);
    step("bnd_b_e7", 1'b1, 1'b0, L | H);
    step("bnd_b_e8", 1'b0, 1'b0, R);
    step("bnd_b_idle", 1'b0, 1'b0, Z);

    // Reset mid-hold at edge 9; re-press at 14.
    step("rmh_e0", 1'b1, 1'b0, P | H);
    for (int e = 1; e < 9; e++) begin
      if (e == 7) step("rmh_long", 1'b1, 1'b0, L | H);
      else        step("rmh_held", 1'b1, 1'b0, H);
    end
    step("rmh_rst_e9", 1'b1, 1'b1, Z);
    step("rmh_e10", 1'b1, 1'b0, Z);
    step("rmh_e11", 1'b1, 1'b0, Z);
    step("rmh_e12", 1'b0, 1'b0, Z);
    step("rmh_e13", 1'b0, 1'b0, Z);
    step("rmh_e14", 1'b1, 1'b0, P | H);
    step("rmh_e15", 1'b0, 1'b0, R | S);
    step("rmh_idle", 1'b0, 1'b0, Z);

    // Simultaneous rst and btn rise: no press until seen low after reset.
    step("sim_rst_rise", 1'b1, 1'b1, Z);
    step("sim_after1", 1'b1, 1'b0, Z);
    step("sim_after2", 1'b1, 1'b0, Z);
    step("sim_low", 1'b0, 1'b0, Z);
    step("sim_press", 1'b1, 1'b0, P | H);
    step("sim_release", 1'b0, 1'b0, R | S);
    step("sim_idle", 1'b0, 1'b0, Z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
